// File: rtl/grav_counter_if.sv
// Control/status bundle for grav_counter. Optional CountDown exists only when
// GRAV_COUNTER_DOWN_EN is defined.
interface grav_counter_if #(
  parameter int unsigned WIDTH = 11
);
  logic             CountEnable;
  logic             Clear;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic             pure_grav;
  logic             Saturate;
  logic [WIDTH-1:0] Count;
  logic             Wrap;
  logic             AtMax;
  logic [1:0]       State;
`ifdef GRAV_COUNTER_DOWN_EN
  logic             CountDown;

  modport master (
    output CountEnable, Clear, Load, LoadValue, pure_grav, Saturate, CountDown,
    input  Count, Wrap, AtMax, State
  );
  modport slave (
    input  CountEnable, Clear, Load, LoadValue, pure_grav, Saturate, CountDown,
    output Count, Wrap, AtMax, State
  );
`else
  modport master (
    output CountEnable, Clear, Load, LoadValue, pure_grav, Saturate,
    input  Count, Wrap, AtMax, State
  );
  modport slave (
    input  CountEnable, Clear, Load, LoadValue, pure_grav, Saturate,
    output Count, Wrap, AtMax, State
  );
`endif
endinterface

// File: rtl/grav_counter.sv
// Parametrised gravity/frame counter with wrap/saturate modes and IDLE/RUN/SAT FSM.
// Define GRAV_COUNTER_DOWN_EN to add the CountDown direction input.
module grav_counter #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned MAX_COUNT   = 1023,
  parameter int unsigned GRAV_PRESET = 340,
  parameter int unsigned STEP        = 1
) (
  input  logic           CLK,
  input  logic           RESET_N,
  grav_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } state_t;

  localparam int unsigned      SUM_W    = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] PRESET_V = WIDTH'(GRAV_PRESET);
  localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
  localparam logic [SUM_W-1:0] MAX_S    = SUM_W'(MAX_COUNT);
  localparam logic [SUM_W-1:0] STEP_S   = SUM_W'(STEP);

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;

  logic             down;
  logic [SUM_W-1:0] up_sum;
  logic [WIDTH-1:0] dn_diff;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step_count;
  state_t           step_state;
  logic             step_wrap;

`ifdef GRAV_COUNTER_DOWN_EN
  assign down = bus.CountDown;
`else
  assign down = 1'b0;
`endif

  assign load_val = (bus.LoadValue > MAX_V) ? MAX_V : bus.LoadValue;

  // Result of one enabled count cycle. The same rules cover IDLE, RUN and SAT:
  // a saturated counter pinned at its bound re-saturates, otherwise it wraps.
  always_comb begin
    step_count = count_q;
    step_state = state_q;
    step_wrap  = 1'b0;
    up_sum     = {1'b0, count_q} + STEP_S;
    dn_diff    = count_q - STEP_V;
    if (!down) begin
      if (up_sum > MAX_S) begin
        if (bus.Saturate) begin
          step_count = MAX_V;
          step_state = SAT;
        end else begin
          step_count = '0;
          step_state = RUN;
          step_wrap  = 1'b1;
        end
      end else if ((up_sum == MAX_S) && bus.Saturate) begin
        step_count = MAX_V;
        step_state = SAT;
      end else begin
        step_count = up_sum[WIDTH-1:0];
        step_state = RUN;
      end
    end else begin
      if (count_q < STEP_V) begin
        if (bus.Saturate) begin
          step_count = '0;
          step_state = SAT;
        end else begin
          step_count = MAX_V;
          step_state = RUN;
          step_wrap  = 1'b1;
        end
      end else if ((count_q == STEP_V) && bus.Saturate) begin
        step_count = '0;
        step_state = SAT;
      end else begin
        step_count = dn_diff;
        step_state = RUN;
      end
    end
  end

  // State, count and wrap pulse; Wrap defaults low so only wrap cycles raise it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.Clear) begin
        state_q <= IDLE;
        count_q <= '0;
      end else if (bus.Load) begin
        state_q <= RUN;
        count_q <= load_val;
      end else if (bus.pure_grav) begin
        state_q <= RUN;
        count_q <= PRESET_V;
      end else if (bus.CountEnable) begin
        state_q <= step_state;
        count_q <= step_count;
        wrap_q  <= step_wrap;
      end
    end
  end

  assign bus.Count = count_q;
  assign bus.Wrap  = wrap_q;
  assign bus.State = state_q;
  assign bus.AtMax = (count_q == MAX_V);

endmodule

// File: doc/grav_counter.md
# grav_counter

Parametrised gravity/frame counter for the sprite motion path. It generalises the fixed 11-bit gravity counter with configurable width, terminal value, step and preset, and adds selectable wrap/saturate mode, external load and an explicit IDLE/RUN/SAT state machine. It also provides a wrap pulse and a terminal flag, so the physics and animation logic downstream no longer decode the count themselves.

## Interface
Parameters:
- WIDTH, 11, counter width in bits
- MAX_COUNT, 1023, terminal value; must be < 2**WIDTH
- GRAV_PRESET, 340, value loaded by pure_grav; must be ≤ MAX_COUNT
- STEP, 1, increment per enabled cycle; must be ≥ 1 and ≤ MAX_COUNT

Ports:
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CountEnable  in  1  advance the count this cycle
- Clear  in  1  synchronous clear to 0 and state IDLE
- Load  in  1  synchronous load of LoadValue
- LoadValue  in  WIDTH  value for Load; clamped to MAX_COUNT
- pure_grav  in  1  synchronous load of GRAV_PRESET
- Saturate  in  1  1 = stop at MAX_COUNT; 0 = wrap to 0
- Count  out  WIDTH  current count, registered
- Wrap  out  1  registered 1-cycle pulse on each wrap to 0
- AtMax  out  1  combinational, Count == MAX_COUNT
- State  out  2  IDLE=0, RUN=1, SAT=2; 3 is never driven

## Operation
- Per-cycle priority: RESET_N low > Clear > Load > pure_grav > CountEnable > hold.
- Clear: Count=0, State=IDLE, Wrap=0.
- Load: Count=min(LoadValue, MAX_COUNT), State=RUN. This applies in any state, including SAT.
- pure_grav: Count=GRAV_PRESET, State=RUN. This applies in any state and does not depend on CountEnable.
- Increment: sum = Count + STEP, computed at WIDTH+1 bits so the carry is never lost.
  - If sum ≤ MAX_COUNT, Count=sum.
  - If sum > MAX_COUNT and Saturate=0, Count=0 (exactly 0; the remainder is discarded), Wrap=1, State=RUN.
  - If sum > MAX_COUNT and Saturate=1, Count=MAX_COUNT, State=SAT.
  - If sum == MAX_COUNT and Saturate=1, Count=MAX_COUNT, State=SAT.
- FSM:
  - IDLE: on CountEnable, go to RUN and apply the increment in the same cycle.
  - RUN: increment as above.
  - SAT: CountEnable is ignored while Saturate=1 and Count holds at MAX_COUNT. If Saturate=0 and CountEnable=1, Count=0, Wrap=1, State=RUN.
- Wrap is 0 on every cycle that is not a wrap, including cycles that perform Load, pure_grav or Clear.
- Saturate may change on any cycle; it is sampled only on increment cycles.

## Timing
- Reset values: Count=0, State=IDLE, Wrap=0. AtMax=1 only if MAX_COUNT==0, which the parameter rules forbid, so AtMax=0.
- Reset assertion takes effect immediately, without waiting for a clock. Deassertion is synchronised by the surrounding reset tree.
- Latency: every input affects Count, State and Wrap at the next rising CLK edge. AtMax follows Count combinationally.
- No handshakes. Inputs are sampled every cycle.
- Reset mid-count returns all outputs to their reset values. A Wrap pulse in flight is cancelled.

## Configuration
- GRAV_COUNTER_DOWN_EN defined:
  - Adds input CountDown (1 bit). When it is 1, an increment cycle subtracts STEP instead of adding it.
  - Underflow (Count < STEP) with Saturate=0: Count=MAX_COUNT, Wrap=1.
  - Underflow with Saturate=1: Count=0, State=SAT.
  - In SAT at 0 with CountDown=1, the count holds.
  - Leaving SAT follows the same rules with the direction mirrored.
- GRAV_COUNTER_DOWN_EN undefined:
  - The CountDown port is absent and counting is up-only, as described above.

## Test plan
- Reset with WIDTH=11, MAX_COUNT=1023, STEP=1: hold CountEnable=1 for 1024 cycles. Count reaches 1023, then 0 with Wrap=1 for exactly one cycle; State goes IDLE→RUN.
- STEP=3, MAX_COUNT=10, Saturate=0: Count sequence is 0,3,6,9,0 (Wrap=1),3. Repeat with Saturate=1: sequence is 0,3,6,9,10, then State=SAT and Count holds at 10 with CountEnable=1.
- In SAT, assert pure_grav: Count=340, State=RUN. Assert Load with LoadValue=2000 (MAX_COUNT=1023): Count=1023, AtMax=1.
- Simultaneous Clear, Load and CountEnable in one cycle: Count=0, State=IDLE. Load with pure_grav: Count=LoadValue. Drop RESET_N between clock edges: Count=0 immediately.
- In SAT, drop Saturate with CountEnable=1: next cycle Count=0, Wrap=1, State=RUN.
- With GRAV_COUNTER_DOWN_EN, MAX_COUNT=10, STEP=1, CountDown=1 from Count=1: Count sequence is 0, then 10 with Wrap=1. With Saturate=1: Count holds at 0, State=SAT.
